i2s_rx: RTL and testbench

I2S_RX -- requirements
Module: i2s_rx

---
 rtl/i2s_rx.sv | 164 ++++++++++++++++
 tb/tb_i2s_rx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// I2S receiver. The bit clock, word select and data pins are synchronised into
// the system clock domain, sampled on each sclk rising edge and assembled into
// signed left/right samples that are published as a pair. Slot length is
// checked at every word-select change; malformed slots raise frame_error and
// drop lock.
module i2s_rx #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_WIDTH   = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sclk,
  input  logic                           lrck,
  input  logic                           sdata,
  output logic signed [SAMPLE_WIDTH-1:0] left,
  output logic signed [SAMPLE_WIDTH-1:0] right,
  output logic                           sample_valid,
  output logic                           frame_error,
  output logic                           locked
);

  localparam logic [1:0] ST_HUNT  = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

  localparam logic [5:0] SLOT_CNT = 6'(SLOT_WIDTH);
  localparam logic [5:0] SMP_CNT  = 6'(SAMPLE_WIDTH);

  // Bit counter increment that sticks at 63, so over-long slots never wrap
  // back to a value that would look well formed.
  function automatic logic [5:0] sat_inc(input logic [5:0] c);
    return (c == 6'd63) ? c : c + 6'd1;
  endfunction

  logic                           r_sclk_p0, r_sclk_p1, r_sclk_p2;
  logic                           r_lrck_p0, r_lrck_p1;
  logic                           r_sdata_p0, r_sdata_p1;
  logic                           r_lrck_prev;
  logic [5:0]                     r_cnt;
  logic signed [SAMPLE_WIDTH-1:0] r_shift;
  logic signed [SAMPLE_WIDTH-1:0] r_hold;
  logic                           r_left_ok;
  logic [1:0]                     r_state;
  logic                           r_vld_p2;
  logic                           r_err_p2;
  logic signed [SAMPLE_WIDTH-1:0] r_left_p2;
  logic signed [SAMPLE_WIDTH-1:0] r_right_p2;

  logic w_strobe;
  logic w_change;
  logic w_good;
  logic w_in_sample;

  assign w_strobe    = r_sclk_p1 & ~r_sclk_p2;
  assign w_change    = w_strobe & (r_lrck_p1 != r_lrck_prev);
  assign w_good      = (r_cnt == SLOT_CNT);
  assign w_in_sample = (r_cnt >= 6'd1) && (r_cnt <= SMP_CNT);

  // Stage p0/p1: two-flop synchronisers; p2: delayed sclk for rising-edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sclk_p0  <= 1'b0;
      r_sclk_p1  <= 1'b0;
      r_sclk_p2  <= 1'b0;
      r_lrck_p0  <= 1'b0;
      r_lrck_p1  <= 1'b0;
      r_sdata_p0 <= 1'b0;
      r_sdata_p1 <= 1'b0;
    end else begin
      r_sclk_p0  <= sclk;
      r_sclk_p1  <= r_sclk_p0;
      r_sclk_p2  <= r_sclk_p1;
      r_lrck_p0  <= lrck;
      r_lrck_p1  <= r_lrck_p0;
      r_sdata_p0 <= sdata;
      r_sdata_p1 <= r_sdata_p0;
    end
  end

  // Stage p2: per-bit slot tracking, slot-length check and pair assembly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lrck_prev <= 1'b0;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_hold      <= '0;
      r_left_ok   <= 1'b0;
      r_state     <= ST_HUNT;
      r_vld_p2    <= 1'b0;
      r_err_p2    <= 1'b0;
      r_left_p2   <= '0;
      r_right_p2  <= '0;
    end else begin
      r_vld_p2 <= 1'b0;
      r_err_p2 <= 1'b0;
      if (w_strobe) begin
        r_lrck_prev <= r_lrck_p1;
        if (w_change) begin
          // Slot bit 0 (the I2S delay bit): close the previous slot, data ignored.
          r_cnt   <= 6'd1;
          r_shift <= '0;
          case (r_state)
            ST_HUNT: begin
              // Only a falling word select gives a trustworthy frame start.
              if (!r_lrck_p1) begin
                r_state   <= ST_LEFT;
                r_left_ok <= 1'b0;
              end
            end
            ST_LEFT: begin
              r_state <= r_lrck_p1 ? ST_RIGHT : ST_LEFT;
              if (w_good) begin
                r_hold    <= r_shift;
                r_left_ok <= 1'b1;
              end else begin
                r_err_p2  <= 1'b1;
                r_left_ok <= 1'b0;
              end
            end
            ST_RIGHT: begin
              r_state   <= r_lrck_p1 ? ST_RIGHT : ST_LEFT;
              r_left_ok <= 1'b0;
              if (!w_good) begin
                r_err_p2 <= 1'b1;
              end else if (r_left_ok) begin
                r_vld_p2   <= 1'b1;
                r_left_p2  <= r_hold;
                r_right_p2 <= r_shift;
              end
            end
            default: r_state <= ST_HUNT;
          endcase
        end else begin
          r_cnt <= sat_inc(r_cnt);
          if (w_in_sample) begin
            r_shift <= {r_shift[SAMPLE_WIDTH-2:0], r_sdata_p1};
          end
        end
      end
    end
  end

  // Stage p3: registered outputs; samples hold between pairs, lock follows events.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      left         <= '0;
      right        <= '0;
      sample_valid <= 1'b0;
      frame_error  <= 1'b0;
      locked       <= 1'b0;
    end else begin
      sample_valid <= r_vld_p2;
      frame_error  <= r_err_p2;
      if (r_vld_p2) begin
        left   <= r_left_p2;
        right  <= r_right_p2;
        locked <= 1'b1;
      end else if (r_err_p2) begin
        locked <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives I2S frames bit by bit with sclk = clk/4 and compares
// the observed event stream against a slot-level model of the receiver rules.
module tb_i2s_rx;

  localparam int SW  = 16;
  localparam int SLW = 32;

  logic clk     = 1'b0;
  logic reset_i = 1'b1;
  logic sclk_i  = 1'b0;
  logic lrck_i  = 1'b0;
  logic sdata_i = 1'b0;
  logic signed [SW-1:0] left_o, right_o;
  logic sv_o, fe_o, locked_o;

  always #5 clk = ~clk;

  i2s_rx #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(SLW)) dut (
    .clk(clk), .reset(reset_i), .sclk(sclk_i), .lrck(lrck_i), .sdata(sdata_i),
    .left(left_o), .right(right_o), .sample_valid(sv_o),
    .frame_error(fe_o), .locked(locked_o)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int left_rise = 0;
  int last_lat  = -1;
  int both_cnt  = 0;

  typedef struct packed {
    logic          err;
    logic [SW-1:0] l;
    logic [SW-1:0] r;
  } ev_t;

  ev_t got_q[$];
  ev_t exp_q[$];

  // Reference model state, expressed per slot rather than per clock.
  int            m_state;  // 0 hunting, 1 in left slot, 2 in right slot
  bit            m_prev;
  int            m_len;
  logic [SW-1:0] m_word, m_hold, m_l, m_r;
  bit            m_lok, m_locked;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset_i) begin
      if (sv_o) begin
        got_q.push_back({1'b0, left_o, right_o});
        last_lat = cyc - left_rise;
      end
      if (fe_o) got_q.push_back({1'b1, {SW{1'b0}}, {SW{1'b0}}});
      if (sv_o && fe_o) both_cnt++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_prev = 1'b0; m_lok = 1'b0; m_locked = 1'b0;
    m_l = '0; m_r = '0; m_word = '0; m_hold = '0;
  endtask

  // A word-select change ends the current slot; judge it by its length.
  task automatic close_slot(input bit new_lr);
    bit good;
    good = (m_len == SLW);
    if (m_state == 0) begin
      if (new_lr == 1'b0) begin m_state = 1; m_lok = 1'b0; end
    end else if (m_state == 1) begin
      m_state = 2;
      if (good) begin m_hold = m_word; m_lok = 1'b1; end
      else begin exp_q.push_back({1'b1, {SW{1'b0}}, {SW{1'b0}}}); m_lok = 1'b0; m_locked = 1'b0; end
    end else begin
      m_state = 1;
      if (!good) begin
        exp_q.push_back({1'b1, {SW{1'b0}}, {SW{1'b0}}});
        m_locked = 1'b0;
      end else if (m_lok) begin
        exp_q.push_back({1'b0, m_hold, m_word});
        m_l = m_hold; m_r = m_word; m_locked = 1'b1;
      end
      m_lok = 1'b0;
    end
    m_word = '0;
  endtask

  // Send n bits on word select lr; slot bit index comes from the running slot length.
  task automatic send_bits(input bit lr, input int n, input logic [SW-1:0] w, input bit zt);
    bit d;
    for (int i = 0; i < n; i++) begin
      if (lr != m_prev) begin close_slot(lr); m_prev = lr; m_len = 0; end
      if (m_len >= 1 && m_len <= SW) begin
        d = w[SW-m_len];
        m_word = {m_word[SW-2:0], d};
      end else begin
        d = zt ? 1'b0 : 1'($urandom);
      end
      @(negedge clk); sclk_i = 1'b0; lrck_i = lr; sdata_i = d;
      repeat (2) @(negedge clk);
      sclk_i = 1'b1;
      if (!lr && m_len == 0) left_rise = cyc;
      @(negedge clk);
      m_len++;
    end
  endtask

  task automatic send_frame(input logic [SW-1:0] l, input logic [SW-1:0] r,
                            input int nl, input int nr, input bit zt);
    int a;
    a = (m_prev == 1'b0) ? m_len : 0;
    send_bits(1'b0, nl - a, l, zt);
    send_bits(1'b1, nr, r, zt);
  endtask

  // Start the next left slot (closing the right one) and compare everything seen.
  task automatic checkpoint(input string tag);
    int n;
    send_bits(1'b0, 1, '0, 1'b0);
    repeat (10) @(negedge clk);
    chk({tag, ".events"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, ".event"}, got_q[i], exp_q[i]);
    chk({tag, ".locked"}, locked_o, m_locked);
    chk({tag, ".left"},  {16'h0, left_o},  m_l);
    chk({tag, ".right"}, {16'h0, right_o}, m_r);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic reset_check(input string tag);
    chk({tag, ".left"},  {16'h0, left_o},  64'h0);
    chk({tag, ".right"}, {16'h0, right_o}, 64'h0);
    chk({tag, ".sv"},     sv_o,     64'h0);
    chk({tag, ".fe"},     fe_o,     64'h0);
    chk({tag, ".locked"}, locked_o, 64'h0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset_i = 1'b1; sclk_i = 1'b0;
    #1;
    reset_check(tag);
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    model_reset();
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [SW-1:0] a, b, hl, hr;
    logic          hk;
    int            nl, nr;
    model_reset();
    m_len = 0;

    repeat (3) @(negedge clk);
    reset_check("reset");
    @(negedge clk);
    reset_i = 1'b0;

    // Two frames: the second one is the first full pair after hunting.
    send_frame(16'h1234, 16'hFEDC, SLW, SLW, 1'b0);
    send_frame(16'h1234, 16'hFEDC, SLW, SLW, 1'b0);
    checkpoint("basic");
    chk("basic.latency", last_lat, 4);
    chk("basic.left_val", {16'h0, left_o}, 64'h1234);
    chk("basic.right_val", {16'h0, right_o}, 64'hFEDC);
    chk("basic.locked_val", locked_o, 64'h1);
    send_frame(16'h0F0F, 16'h7001, SLW, SLW, 1'b0);
    send_frame(16'hA5C3, 16'h0002, SLW, SLW, 1'b0);
    checkpoint("basic2");

    // MSB-only sample with zero delay bit and zero tail.
    send_frame(16'h8000, 16'($urandom), SLW, SLW, 1'b1);
    checkpoint("msb");
    chk("msb.left_val", {16'h0, left_o}, 64'h8000);

    // Short right slot, then recovery.
    send_frame(16'($urandom), 16'($urandom), SLW, SLW - 1, 1'b0);
    checkpoint("short");
    chk("short.locked_val", locked_o, 64'h0);
    send_frame(16'h4321, 16'h9ABC, SLW, SLW, 1'b0);
    checkpoint("recover");
    chk("recover.locked_val", locked_o, 64'h1);

    // Random data with occasional malformed slot lengths (including saturation).
    for (int f = 0; f < 16; f++) begin
      nl = SLW; nr = SLW;
      case ($urandom_range(0, 7))
        0: nl = SLW - 1;
        1: nr = SLW + 1;
        2: nl = 70;
        3: nr = SLW - 3;
        default: ;
      endcase
      send_frame(16'($urandom), 16'($urandom), nl, nr, 1'b0);
      if (f % 4 == 3) checkpoint("random");
    end
    send_frame(16'($urandom), 16'($urandom), SLW, SLW, 1'b0);
    checkpoint("relock");

    // Reset during bit 8 of a left slot, then a full frame.
    a = 16'($urandom);
    send_bits(1'b0, 8, a, 1'b0);
    do_reset("midreset");
    send_bits(1'b0, SLW - 9, a, 1'b0);
    send_bits(1'b1, SLW, 16'($urandom), 1'b0);
    send_frame(16'h1357, 16'h2468, SLW, SLW, 1'b0);
    checkpoint("after_reset");
    chk("after_reset.left_val", {16'h0, left_o}, 64'h1357);
    chk("after_reset.right_val", {16'h0, right_o}, 64'h2468);

    // Start in the middle of a right slot.
    do_reset("hunt_reset");
    send_bits(1'b1, 12, 16'($urandom), 1'b0);
    send_frame(16'hCAFE, 16'h0BAD, SLW, SLW, 1'b0);
    checkpoint("midright");
    chk("midright.left_val", {16'h0, left_o}, 64'hCAFE);

    // sclk stops for 1000 clk in the middle of a left slot.
    a = 16'($urandom); b = 16'($urandom);
    send_bits(1'b0, 10, a, 1'b0);
    hl = left_o; hr = right_o; hk = locked_o;
    repeat (1000) @(negedge clk);
    chk("stop.events", got_q.size(), 0);
    chk("stop.left", {16'h0, left_o}, hl);
    chk("stop.right", {16'h0, right_o}, hr);
    chk("stop.locked", locked_o, hk);
    send_bits(1'b0, SLW - 11, a, 1'b0);
    send_bits(1'b1, SLW, b, 1'b0);
    checkpoint("resume");
    chk("resume.left_val", {16'h0, left_o}, a);

    chk("exclusive", both_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
